// File: rtl/pipeline_hazard_ctrl.sv
// Issue controller: per-register RAW scoreboard, control-hazard freeze/flush,
// stall statistics and a CTRL_WAIT watchdog.
module pipeline_hazard_ctrl #(
    parameter int unsigned MAX_WAIT    = 7,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic                   id_rs1_used,
    input  logic                   id_rs2_used,
    input  logic [4:0]             id_rd,
    input  logic                   id_rd_write,
    input  logic                   id_is_ctrl,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_rd,
    input  logic                   wb_write,
    input  logic                   wb_ctrl,
    input  logic                   wb_redirect,
    output logic                   issue,
    output logic                   stall_if,
    output logic                   bubble_ex,
    output logic                   flush,
    output logic [31:0]            busy_mask,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic                   wd_err,
    output logic [1:0]             state
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        CTRL_WAIT = 2'd1,
        FLUSH     = 2'd2
    } state_e;

    localparam logic [3:0] WD_MAX = 4'(MAX_WAIT);

    state_e                 state_q, state_d;
    logic [1:0]             cnt_q [32];
    logic [1:0]             cnt_d [32];
    logic [3:0]             wd_q, wd_d;
    logic                   wd_err_q, wd_err_d;
    logic [STALL_CNT_W-1:0] sc_q, sc_d;
    logic                   raw;

    // A register retiring this cycle still reads as busy: cnt_q is pre-edge.
    assign raw = id_valid &
                 ((id_rs1_used & (id_rs1 != 5'd0) & (cnt_q[id_rs1] != 2'd0)) |
                  (id_rs2_used & (id_rs2 != 5'd0) & (cnt_q[id_rs2] != 2'd0)));

    always_comb begin
        issue     = 1'b0;
        stall_if  = 1'b0;
        bubble_ex = 1'b0;
        flush     = 1'b0;
        unique case (state_q)
            CTRL_WAIT: begin
                stall_if  = 1'b1;
                bubble_ex = 1'b1;
            end
            FLUSH: begin
                bubble_ex = 1'b1;
                flush     = 1'b1;
            end
            default: begin
                issue     = id_valid & ~raw;
                stall_if  = id_valid & raw;
                bubble_ex = ~id_valid | raw;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        wd_d     = wd_q;
        wd_err_d = wd_err_q;
        unique case (state_q)
            RUN: begin
                if (issue && id_is_ctrl) begin
                    state_d = CTRL_WAIT;
                    wd_d    = 4'd0;
                end
            end
            CTRL_WAIT: begin
                wd_d = wd_q + 4'd1;
                if (wb_valid && wb_ctrl) begin
                    state_d = wb_redirect ? FLUSH : RUN;
                end else if (wd_d == WD_MAX) begin
                    wd_err_d = 1'b1;
                    state_d  = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        cnt_d[0] = 2'd0;
        for (int r = 1; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
            if (issue && id_rd_write && (id_rd == 5'(r)) &&
                !(wb_valid && wb_write && (wb_rd == 5'(r)))) begin
                if (cnt_q[r] != 2'd3) cnt_d[r] = cnt_q[r] + 2'd1;
            end else if (wb_valid && wb_write && (wb_rd == 5'(r)) &&
                         !(issue && id_rd_write && (id_rd == 5'(r)))) begin
                if (cnt_q[r] != 2'd0) cnt_d[r] = cnt_q[r] - 2'd1;
            end
        end
    end

    always_comb begin
        busy_mask[0] = 1'b0;
        for (int r = 1; r < 32; r++) begin
            busy_mask[r] = (cnt_q[r] != 2'd0);
        end
    end

    assign sc_d = (bubble_ex && !(&sc_q)) ? sc_q + 1'b1 : sc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            wd_q     <= 4'd0;
            wd_err_q <= 1'b0;
            sc_q     <= '0;
            for (int r = 0; r < 32; r++) cnt_q[r] <= 2'd0;
        end else begin
            state_q  <= state_d;
            wd_q     <= wd_d;
            wd_err_q <= wd_err_d;
            sc_q     <= sc_d;
            for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    assign stall_cycles = sc_q;
    assign wd_err       = wd_err_q;
    assign state        = state_q;

endmodule
